// File: rtl/sdram_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sdram_pkg
//  Description : Shared SDRAM command encodings, init-sequencer state
//                encoding and default timing values.
//  Revision    : 1.0 - initial release
// ============================================================================
package sdram_pkg;

    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CMD_NOP       = 4'b0111;
    localparam logic [3:0] CMD_PRECHARGE = 4'b0010;
    localparam logic [3:0] CMD_REFRESH   = 4'b0001;
    localparam logic [3:0] CMD_LOAD_MODE = 4'b0000;
    localparam logic [3:0] CMD_DESELECT  = 4'b1111;

    // A10 high selects "all banks" for PRECHARGE
    localparam logic [12:0] ADDR_A10 = 13'h0400;

    // Default timing, shared with the read/write controller
    localparam int          DEF_POWERUP_CYCLES = 20000;
    localparam int          DEF_T_RP           = 2;
    localparam int          DEF_T_RFC          = 7;
    localparam int          DEF_T_MRD          = 2;
    localparam int          DEF_REFRESH_COUNT  = 2;
    localparam logic [12:0] DEF_MODE_REG       = 13'h032;

    typedef enum logic [3:0] {
        ST_WAIT_LOCK = 4'd0,
        ST_POWERUP   = 4'd1,
        ST_PRECHARGE = 4'd2,
        ST_WAIT_RP   = 4'd3,
        ST_REFRESH   = 4'd4,
        ST_WAIT_RFC  = 4'd5,
        ST_LOAD_MODE = 4'd6,
        ST_WAIT_MRD  = 4'd7,
        ST_DONE      = 4'd8
    } init_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
//  Module      : sync_2ff
//  Description : 1-bit two-flop synchronizer, asynchronous active-low reset
//                to 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // Two flops in series give the first stage a full cycle to resolve
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sdram_init_seq.sv
`default_nettype none
// ============================================================================
//  Module      : sdram_init_seq
//  Description : SDRAM power-up initialisation sequencer. After the DCM
//                lock is stable: CKE high + power-up wait, PRECHARGE ALL,
//                N x AUTO REFRESH, LOAD MODE REGISTER, then init_done.
//  Revision    : 1.0 - initial release
// ============================================================================
module sdram_init_seq
    import sdram_pkg::*;
#(
    parameter int          POWERUP_CYCLES = DEF_POWERUP_CYCLES,
    parameter int          T_RP           = DEF_T_RP,
    parameter int          T_RFC          = DEF_T_RFC,
    parameter int          T_MRD          = DEF_T_MRD,
    parameter int          REFRESH_COUNT  = DEF_REFRESH_COUNT,
    parameter logic [12:0] MODE_REG       = DEF_MODE_REG
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dcm_locked,
    output logic        init_done,
    output logic        init_busy,
    output logic        sdram_cke,
    output logic        sdram_cs_n,
    output logic        sdram_ras_n,
    output logic        sdram_cas_n,
    output logic        sdram_we_n,
    output logic [1:0]  sdram_ba,
    output logic [12:0] sdram_addr
);

    localparam int CNT_W = $clog2(max_int(POWERUP_CYCLES, T_RFC) + 1);
    localparam int REF_W = $clog2(REFRESH_COUNT + 1);

    // Counter load values: a state exits when the counter reads zero
    localparam logic [CNT_W-1:0] LD_POWERUP = CNT_W'(POWERUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] LD_RP      = CNT_W'(T_RP - 1);
    localparam logic [CNT_W-1:0] LD_RFC     = CNT_W'(T_RFC - 1);
    localparam logic [CNT_W-1:0] LD_MRD     = CNT_W'(T_MRD - 1);
    localparam logic [REF_W-1:0] REF_LAST   = REF_W'(REFRESH_COUNT);

    init_state_t      state;
    logic [CNT_W-1:0] cnt;
    logic [REF_W-1:0] ref_cnt;
    logic [3:0]       cmd;
    logic             lock_s;
    logic             cnt_zero;

    sync_2ff u_lock_sync (
        .clk   (clk),
        .rst_n (rst),
        .d     (dcm_locked),
        .q     (lock_s)
    );

    assign cnt_zero = (cnt == '0);
    assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd;

    // Sequencer: every command is a one-cycle pulse; NOP fills all other
    // cycles while CKE is high. Losing lock anywhere drops back to idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_WAIT_LOCK;
            cnt        <= '0;
            ref_cnt    <= '0;
            cmd        <= CMD_DESELECT;
            sdram_cke  <= 1'b0;
            sdram_ba   <= '0;
            sdram_addr <= '0;
            init_done  <= 1'b0;
            init_busy  <= 1'b0;
        end else if (state != ST_WAIT_LOCK && !lock_s) begin
            state      <= ST_WAIT_LOCK;
            cnt        <= '0;
            ref_cnt    <= '0;
            cmd        <= CMD_DESELECT;
            sdram_cke  <= 1'b0;
            sdram_ba   <= '0;
            sdram_addr <= '0;
            init_done  <= 1'b0;
            init_busy  <= 1'b0;
        end else begin
            cmd        <= CMD_NOP;
            sdram_ba   <= '0;
            sdram_addr <= '0;
            case (state)
                ST_WAIT_LOCK: begin
                    cmd <= CMD_DESELECT;
                    if (lock_s) begin
                        state     <= ST_POWERUP;
                        cnt       <= LD_POWERUP;
                        cmd       <= CMD_NOP;
                        sdram_cke <= 1'b1;
                        init_busy <= 1'b1;
                    end
                end
                ST_POWERUP: begin
                    if (cnt_zero) begin
                        state      <= ST_PRECHARGE;
                        cnt        <= LD_RP;
                        ref_cnt    <= '0;
                        cmd        <= CMD_PRECHARGE;
                        sdram_addr <= ADDR_A10;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_PRECHARGE, ST_WAIT_RP: begin
                    if (cnt_zero) begin
                        state   <= ST_REFRESH;
                        cnt     <= LD_RFC;
                        ref_cnt <= ref_cnt + 1'b1;
                        cmd     <= CMD_REFRESH;
                    end else begin
                        state <= ST_WAIT_RP;
                        cnt   <= cnt - 1'b1;
                    end
                end
                ST_REFRESH, ST_WAIT_RFC: begin
                    if (cnt_zero) begin
                        if (ref_cnt < REF_LAST) begin
                            state   <= ST_REFRESH;
                            cnt     <= LD_RFC;
                            ref_cnt <= ref_cnt + 1'b1;
                            cmd     <= CMD_REFRESH;
                        end else begin
                            state      <= ST_LOAD_MODE;
                            cnt        <= LD_MRD;
                            cmd        <= CMD_LOAD_MODE;
                            sdram_addr <= MODE_REG;
                        end
                    end else begin
                        state <= ST_WAIT_RFC;
                        cnt   <= cnt - 1'b1;
                    end
                end
                ST_LOAD_MODE, ST_WAIT_MRD: begin
                    if (cnt_zero) begin
                        state     <= ST_DONE;
                        init_done <= 1'b1;
                        init_busy <= 1'b0;
                    end else begin
                        state <= ST_WAIT_MRD;
                        cnt   <= cnt - 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_DONE;
                end
                default: begin
                    state <= ST_WAIT_LOCK;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sdram_init_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sdram_init_seq
//  Description : Self-checking bench for sdram_init_seq. Two instances:
//                A (2 refreshes, tRFC=7) and B (8 refreshes, tRFC=1) share
//                clock, reset and lock.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sdram_init_seq;

    logic clk = 1'b0;
    logic rst;
    logic dcm_locked;

    always #5 clk = ~clk;

    logic        a_done, a_busy, a_cke, a_cs, a_ras, a_cas, a_we;
    logic [1:0]  a_ba;
    logic [12:0] a_addr;
    logic        b_done, b_busy, b_cke, b_cs, b_ras, b_cas, b_we;
    logic [1:0]  b_ba;
    logic [12:0] b_addr;

    sdram_init_seq #(
        .POWERUP_CYCLES(10), .T_RP(2), .T_RFC(7), .T_MRD(2),
        .REFRESH_COUNT(2), .MODE_REG(13'h032)
    ) dut_a (
        .clk(clk), .rst(rst), .dcm_locked(dcm_locked),
        .init_done(a_done), .init_busy(a_busy), .sdram_cke(a_cke),
        .sdram_cs_n(a_cs), .sdram_ras_n(a_ras), .sdram_cas_n(a_cas),
        .sdram_we_n(a_we), .sdram_ba(a_ba), .sdram_addr(a_addr)
    );

    sdram_init_seq #(
        .POWERUP_CYCLES(10), .T_RP(2), .T_RFC(1), .T_MRD(2),
        .REFRESH_COUNT(8), .MODE_REG(13'h032)
    ) dut_b (
        .clk(clk), .rst(rst), .dcm_locked(dcm_locked),
        .init_done(b_done), .init_busy(b_busy), .sdram_cke(b_cke),
        .sdram_cs_n(b_cs), .sdram_ras_n(b_ras), .sdram_cas_n(b_cas),
        .sdram_we_n(b_we), .sdram_ba(b_ba), .sdram_addr(b_addr)
    );

    // Packed view: [21]=cke [20:17]=cmd [16:15]=ba [14:2]=addr [1]=done [0]=busy
    logic [21:0] got [2];
    assign got[0] = {a_cke, a_cs, a_ras, a_cas, a_we, a_ba, a_addr, a_done, a_busy};
    assign got[1] = {b_cke, b_cs, b_ras, b_cas, b_we, b_ba, b_addr, b_done, b_busy};

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     nm, act, act, exp, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------------
    // Model: lock is seen two edges late; the sequence is "active" from
    // the edge after lock is seen, and outputs depend only on the cycle
    // offset t since CKE rose.
    // ------------------------------------------------------------------
    bit m_l1, m_ls, m_active;
    int m_t;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_l1 = 1'b0; m_ls = 1'b0; m_active = 1'b0; m_t = 0;
        end else begin
            if (!m_active) begin
                if (m_ls) begin m_active = 1'b1; m_t = 0; end
            end else if (!m_ls) begin
                m_active = 1'b0;
            end else begin
                m_t++;
            end
            m_ls = m_l1;
            m_l1 = dcm_locked;
        end
    end

    function automatic logic [21:0] model_out(input bit active, input int t,
            input int pu, input int trp, input int trfc, input int tmrd,
            input int nref, input logic [12:0] mode);
        logic [3:0]  c;
        logic [12:0] ad;
        logic        dn;
        int          r0, l;
        if (!active) return {1'b0, 4'b1111, 2'b00, 13'h0, 1'b0, 1'b0};
        r0 = pu + trp;
        l  = r0 + nref * trfc;
        c  = 4'b0111;
        ad = 13'h0;
        if (t == pu) begin
            c = 4'b0010; ad = 13'h0400;
        end else if (t >= r0 && t < l && ((t - r0) % trfc) == 0) begin
            c = 4'b0001;
        end else if (t == l) begin
            c = 4'b0000; ad = mode;
        end
        dn = (t >= l + tmrd);
        return {1'b1, c, 2'b00, ad, dn, ~dn};
    endfunction

    // Per-cycle compare of both instances against the model
    always @(negedge clk) begin
        logic [21:0] e [2];
        e[0] = model_out(m_active, m_t, 10, 2, 7, 2, 2, 13'h032);
        e[1] = model_out(m_active, m_t, 10, 2, 1, 2, 8, 13'h032);
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (got[i] !== e[i]) begin
                n_fail++;
                $display("FAIL cycle_cmp dut%0d cycle %0d: got cke=%b cmd=%b ba=%0d addr=%h done=%b busy=%b, expected cke=%b cmd=%b ba=%0d addr=%h done=%b busy=%b",
                         i, cyc, got[i][21], got[i][20:17], got[i][16:15], got[i][14:2], got[i][1], got[i][0],
                         e[i][21], e[i][20:17], e[i][16:15], e[i][14:2], e[i][1], e[i][0]);
            end
        end
    end

    // Event recorder: cycles of CKE rise, commands and init_done rise
    int   ev_c [2], ev_pre [2], ev_load [2], ev_done [2], ev_nref [2];
    int   ev_ref [2][16];
    logic prev_cke [2] = '{1'b0, 1'b0};
    logic prev_dn  [2] = '{1'b0, 1'b0};

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (got[i][21] && !prev_cke[i]) begin
                ev_c[i] = cyc; ev_pre[i] = -1; ev_load[i] = -1;
                ev_done[i] = -1; ev_nref[i] = 0;
            end
            if (got[i][21]) begin
                case (got[i][20:17])
                    4'b0010: if (got[i][12]) ev_pre[i] = cyc;
                    4'b0001: begin
                        if (ev_nref[i] < 16) ev_ref[i][ev_nref[i]] = cyc;
                        ev_nref[i]++;
                    end
                    4'b0000: if (got[i][14:2] == 13'h032 && got[i][16:15] == 2'b00) ev_load[i] = cyc;
                    default: ;
                endcase
            end
            if (got[i][1] && !prev_dn[i]) ev_done[i] = cyc;
            prev_cke[i] = got[i][21];
            prev_dn[i]  = got[i][1];
        end
    end

    task automatic check_seq(input int i, input int nref, input int ref0,
                             input int step, input int load, input int done);
        chk($sformatf("pre_offset_dut%0d", i), ev_pre[i] - ev_c[i], 10);
        chk($sformatf("ref_count_dut%0d", i), ev_nref[i], nref);
        for (int k = 0; k < nref && k < 16; k++)
            chk($sformatf("ref%0d_offset_dut%0d", k, i), ev_ref[i][k] - ev_c[i], ref0 + k * step);
        chk($sformatf("load_offset_dut%0d", i), ev_load[i] - ev_c[i], load);
        chk($sformatf("done_offset_dut%0d", i), ev_done[i] - ev_c[i], done);
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!(a_done && b_done) && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        chk("done_within_budget", int'(a_done && b_done), 1);
        @(negedge clk); #1;
    endtask

    task automatic check_idle(input string nm);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("%s_cke_dut%0d", nm, i), int'(got[i][21]), 0);
            chk($sformatf("%s_cmd_dut%0d", nm, i), int'(got[i][20:17]), 15);
            chk($sformatf("%s_done_dut%0d", nm, i), int'(got[i][1]), 0);
            chk($sformatf("%s_busy_dut%0d", nm, i), int'(got[i][0]), 0);
        end
    endtask

    int lock_edge;

    initial begin
        rst = 1'b1; dcm_locked = 1'b0;
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_vec_dut0", int'(got[0]), 32'h1E0000);
        chk("reset_vec_dut1", int'(got[1]), 32'h1E0000);
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;

        // Lock low for a long time: nothing moves
        repeat (1000) @(posedge clk);
        #1 check_idle("nolock");

        // First full sequence
        @(posedge clk); #2 dcm_locked = 1'b1; lock_edge = cyc;
        wait_done(200);
        chk("cke_lag", ev_c[0] - lock_edge, 3);
        check_seq(0, 2, 12, 7, 26, 28);
        check_seq(1, 8, 12, 1, 20, 22);

        // Lock loss after done, then relock
        @(posedge clk); #2 dcm_locked = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_idle("loss_after_done");
        repeat (20) @(posedge clk);
        #2 dcm_locked = 1'b1; lock_edge = cyc;
        wait_done(200);
        chk("relock_cke_lag", ev_c[0] - lock_edge, 3);
        chk("relock_done_offset", ev_done[0] - ev_c[0], 28);

        // Lock loss between refreshes (C+15)
        @(posedge clk); #2 dcm_locked = 1'b0;
        repeat (20) @(posedge clk);
        #2 dcm_locked = 1'b1; lock_edge = cyc;
        do begin @(posedge clk); #2; end while (cyc < lock_edge + 18);
        chk("mid_busy_before_loss", int'(a_busy), 1);
        dcm_locked = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_idle("loss_mid_seq");
        repeat (10) @(posedge clk);
        #2 dcm_locked = 1'b1;
        wait_done(200);
        check_seq(0, 2, 12, 7, 26, 28);
        check_seq(1, 8, 12, 1, 20, 22);

        // Asynchronous reset pulse at C+20 with lock held high
        @(posedge clk); #2 dcm_locked = 1'b0;
        repeat (20) @(posedge clk);
        #2 dcm_locked = 1'b1; lock_edge = cyc;
        do begin @(posedge clk); #2; end while (cyc < lock_edge + 23);
        rst = 1'b0;
        #1 check_idle("async_rst");
        @(posedge clk); #2 rst = 1'b1; lock_edge = cyc;
        wait_done(200);
        chk("post_rst_cke_lag", ev_c[0] - lock_edge, 3);
        check_seq(0, 2, 12, 7, 26, 28);
        check_seq(1, 8, 12, 1, 20, 22);

        repeat (5) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/sdram_init_seq.md
Name: sdram_init_seq

Overview:
SDRAM power-up initialisation sequencer. It is clocked by the buffered SDRAM clock (`out_clk`) from the DCM clock generator, and consumes that generator's `locked` flag. Once lock is stable, it drives the JEDEC init sequence onto the SDRAM command bus:
- CKE high, then the power-up wait
- PRECHARGE ALL
- N × AUTO REFRESH
- LOAD MODE REGISTER

It then raises `init_done`, which hands the bus to the SDRAM read/write controller.

Parameters:
- POWERUP_CYCLES, 20000, NOP cycles with CKE high before PRECHARGE (200 µs at 100 MHz); must be ≥ 1
- T_RP, 2, cycles from PRECHARGE to next command; must be ≥ 1
- T_RFC, 7, cycles from AUTO REFRESH to next command; must be ≥ 1
- T_MRD, 2, cycles from LOAD MODE to `init_done`; must be ≥ 1
- REFRESH_COUNT, 2, number of AUTO REFRESH commands; must be ≥ 1
- MODE_REG, 13'h032, value driven on `sdram_addr` during LOAD MODE (CAS 3, burst 4, sequential)

Ports:
- clk  in  1  SDRAM clock (`out_clk` of the clock generator)
- rst  in  1  reset; asynchronous, active-low
- dcm_locked  in  1  DCM lock flag; asynchronous to `clk`
- init_done  out  1  high when the sequence is complete and the bus may be released
- init_busy  out  1  high from CKE assertion until `init_done`
- sdram_cke  out  1  clock enable
- sdram_cs_n  out  1  chip select
- sdram_ras_n  out  1  row address strobe
- sdram_cas_n  out  1  column address strobe
- sdram_we_n  out  1  write enable
- sdram_ba  out  2  bank address
- sdram_addr  out  13  address / mode bus

Behaviour:
- All outputs are registered.
- Reset values:
  - `sdram_cke`=0
  - `sdram_cs_n`=1, `sdram_ras_n`=1, `sdram_cas_n`=1, `sdram_we_n`=1 (DESELECT)
  - `sdram_ba`=0, `sdram_addr`=0
  - `init_done`=0, `init_busy`=0
- `dcm_locked` passes through a 2-flop synchronizer, giving `lock_s`.
- Command encodings {cs_n, ras_n, cas_n, we_n}:
  - NOP = 0111
  - PRECHARGE = 0010, with A10=1
  - AUTO REFRESH = 0001
  - LOAD MODE = 0000, with ba=0 and addr=MODE_REG
  - DESELECT = 1111
- Each command is valid for exactly one cycle. NOP is driven in every other cycle after CKE rises.
- One down-counter, width $clog2(max(POWERUP_CYCLES, T_RFC)+1), is shared by all wait states. It loads on state entry; the state exits when the counter reads 0 after loading value-1.
- A refresh counter, width $clog2(REFRESH_COUNT+1), is cleared on entry to PRECHARGE.
- FSM states and transitions:
  - WAIT_LOCK: outputs at reset values. When `lock_s`=1, go to POWERUP and set `cke`=1, `init_busy`=1.
  - POWERUP: NOP for POWERUP_CYCLES cycles, then PRECHARGE.
  - PRECHARGE: issue the command, then WAIT_RP (T_RP cycles total, counted from the command cycle).
  - WAIT_RP: go to REFRESH.
  - REFRESH: issue the command and increment the refresh counter, then WAIT_RFC (T_RFC cycles total).
  - WAIT_RFC: go to REFRESH if count < REFRESH_COUNT, else LOAD_MODE.
  - LOAD_MODE: issue the command, then WAIT_MRD (T_MRD cycles total).
  - WAIT_MRD: go to DONE.
  - DONE: `init_done`=1, `init_busy`=0, `cke` stays 1, command NOP. Terminal state.
- Cycle timing, with C = first cycle `cke`=1 on the pins:
  - PRECHARGE on the bus at C+POWERUP_CYCLES = P
  - first REFRESH at P+T_RP
  - k-th REFRESH at P+T_RP+(k-1)·T_RFC
  - LOAD MODE at P+T_RP+REFRESH_COUNT·T_RFC = L
  - `init_done` rises at L+T_MRD
- Lock loss: if `lock_s`=0 in any state except WAIT_LOCK, the next edge returns to WAIT_LOCK and all outputs take their reset values, including in DONE. When lock returns, the full sequence restarts from POWERUP.
- Reset mid-sequence: all outputs go to reset values immediately (asynchronous). After `rst` deasserts, the block waits in WAIT_LOCK.
- `dcm_locked` glitches shorter than one `clk` period may be missed. This is acceptable; the DCM holds `locked` low for many cycles on loss.

Decomposition:
- Package `sdram_pkg` holds:
  - localparams for the 4-bit command encodings (CMD_NOP, CMD_PRECHARGE, CMD_REFRESH, CMD_LOAD_MODE, CMD_DESELECT)
  - the FSM state enum constants
  - default timing values, shared with the read/write controller
- One sub-module: `sync_2ff`, a 1-bit two-flop synchronizer with asynchronous active-low reset to 0, used for `dcm_locked`.

Test Plan:
- Params POWERUP=10, T_RP=2, T_RFC=7, T_MRD=2, REFRESH_COUNT=2; `rst` low for 5 cycles then high; `dcm_locked` high at cycle 10 → expect:
  - `cke` rises 3 edges later (cycle C)
  - PRECHARGE with addr[10]=1 at C+10
  - REFRESH at C+12 and C+19
  - LOAD MODE with addr=13'h032, ba=0 at C+26
  - `init_done`=1 from C+28
  - NOP on every other cycle
- During reset, and with `dcm_locked`=0 held for 1000 cycles → every output stays at its reset value: DESELECT, `cke`=0, `init_done`=0.
- Drop `dcm_locked` at C+15 (between refreshes) → within 3 edges: `cke`=0, DESELECT, `init_busy`=0. Re-assert lock → full sequence again with the same relative timing.
- After `init_done`, drop `dcm_locked` → `init_done` falls within 3 edges and `cke`=0. Re-lock → `init_done` rises again 28 cycles after the new C.
- Assert `rst` low at C+20 for 1 cycle, asynchronously mid-cycle → outputs go to reset values before the next edge. With lock still high, the sequence restarts and PRECHARGE appears 10 cycles after the new `cke` rise.
- REFRESH_COUNT=8, T_RFC=1 → 8 back-to-back REFRESH commands on consecutive cycles, then LOAD MODE on the following cycle.
